// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_word_tx
// Brief   : 4-deep word FIFO feeding a UART that sends each word as two
//           8N2 frames, high byte first.
// Rev     : 1.0
// ============================================================================
module uart_word_tx #(
  parameter int BAUD_DIV   = 1157,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  CLOCK1,
  input  logic                  RESET,
  input  logic                  iCall,
  input  logic [15:0]           iData,
  output logic                  oDone,
  output logic [DEPTH_LOG2:0]   oLevel,
  output logic                  oBusy,
  output logic                  TXD
);

  localparam int                  c_DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  c_CW       = $clog2(BAUD_DIV);
  localparam logic [c_CW-1:0]     c_CNT_LAST = c_CW'(BAUD_DIV - 1);
  localparam logic [c_CW-1:0]     c_CNT_PRE  = c_CW'(BAUD_DIV - 2);
  localparam logic [DEPTH_LOG2:0] c_FULL     = (DEPTH_LOG2 + 1)'(c_DEPTH);
  localparam logic [3:0]          c_BIT_LAST = 4'd10;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_NEXT  = 2'd2;

  logic [15:0]           r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_done;

  logic [1:0]            r_state;
  logic [10:0]           r_frame;
  logic [7:0]            r_lo_byte;
  logic                  r_byte_flag;
  logic [c_CW-1:0]       r_baud_cnt;
  logic [3:0]            r_bit_idx;

  logic                  w_push;
  logic                  w_pop;
  logic [15:0]           w_head;

  // The registered oDone masks a second accept while the caller reacts to it.
  assign w_push = iCall & ~r_done & (r_level != c_FULL);
  assign w_pop  = (r_state == c_IDLE) & (r_level != '0);
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge CLOCK1) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= iData;
    end
  end

  always_ff @(posedge CLOCK1 or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_push;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // TXD is frame bit 0; shifting in ones leaves the line idle once a frame ends.
  // The last stop bit is split SHIFT/NEXT so the NEXT decision costs no line time.
  always_ff @(posedge CLOCK1 or negedge RESET) begin
    if (!RESET) begin
      r_state     <= c_IDLE;
      r_frame     <= 11'h7FF;
      r_lo_byte   <= 8'h00;
      r_byte_flag <= 1'b0;
      r_baud_cnt  <= '0;
      r_bit_idx   <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_frame <= 11'h7FF;
          if (w_pop) begin
            r_frame     <= {2'b11, w_head[15:8], 1'b0};
            r_lo_byte   <= w_head[7:0];
            r_byte_flag <= 1'b0;
            r_baud_cnt  <= '0;
            r_bit_idx   <= 4'd0;
            r_state     <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          if ((r_bit_idx == c_BIT_LAST) && (r_baud_cnt == c_CNT_PRE)) begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
            r_state    <= c_NEXT;
          end else if (r_baud_cnt == c_CNT_LAST) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= r_bit_idx + 1'b1;
            r_frame    <= {1'b1, r_frame[10:1]};
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        c_NEXT: begin
          r_baud_cnt <= '0;
          r_bit_idx  <= 4'd0;
          if (!r_byte_flag) begin
            r_frame     <= {2'b11, r_lo_byte, 1'b0};
            r_byte_flag <= 1'b1;
            r_state     <= c_SHIFT;
          end else begin
            r_frame <= 11'h7FF;
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_frame <= 11'h7FF;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign oDone  = r_done;
  assign oLevel = r_level;
  assign oBusy  = (r_level != '0) | (r_state != c_IDLE);
  assign TXD    = r_frame[0];

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// tb_uart_word_tx: directed pushes queue expected frames; a UART monitor
// decodes TXD and compares each frame and its start-to-start spacing.
module tb_uart_word_tx;

  localparam int c_B     = 13;
  localparam int c_FRAME = 11 * c_B;
  localparam int c_WGAP  = 11 * c_B + 1;

  logic        CLOCK1 = 1'b0;
  logic        RESET;
  logic        iCall;
  logic [15:0] iData;
  logic        oDone;
  logic [2:0]  oLevel;
  logic        oBusy;
  logic        TXD;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } sb_t;

  sb_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          max_level = 0;
  bit          mon_abort = 1'b0;
  logic [15:0] t2_w [6];

  uart_word_tx #(.BAUD_DIV(c_B), .DEPTH_LOG2(2)) dut (
    .CLOCK1 (CLOCK1),
    .RESET  (RESET),
    .iCall  (iCall),
    .iData  (iData),
    .oDone  (oDone),
    .oLevel (oLevel),
    .oBusy  (oBusy),
    .TXD    (TXD)
  );

  always #5 CLOCK1 = ~CLOCK1;

  always @(posedge CLOCK1) cyc <= cyc + 1;

  always @(negedge CLOCK1) begin
    if (int'(oLevel) > max_level) max_level <= int'(oLevel);
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void sb_push_word(logic [15:0] d, int gap_hi);
    sb.push_back('{d[15:8], gap_hi});
    sb.push_back('{d[7:0], c_FRAME});
  endfunction

  task automatic wait_done(input int bound, output int waited);
    waited = 0;
    do begin
      @(posedge CLOCK1); #1;
      waited++;
    end while (!oDone && waited < bound);
    check("handshake_timeout", oDone, 1);
  endtask

  task automatic push(input logic [15:0] d, input int bound, output int waited);
    iData = d;
    iCall = 1'b1;
    wait_done(bound, waited);
    iCall = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((oBusy || sb.size() != 0) && n < bound) begin
      @(posedge CLOCK1); #1;
      n++;
    end
    check("drain_busy", oBusy, 0);
    check("drain_sb", sb.size(), 0);
    repeat (3) @(posedge CLOCK1);
    #1;
  endtask

  // UART monitor: samples mid-bit; a frame cut by reset is abandoned unscored.
  initial begin
    int          st;
    int          prev_start;
    bit          abandon;
    logic [10:0] bits;
    sb_t         e;
    prev_start = -100000;
    forever begin
      @(negedge CLOCK1);
      if (!mon_abort && RESET === 1'b1 && TXD === 1'b0) begin
        st = cyc;
        abandon = 1'b0;
        for (int k = 0; k < 11; k++) begin
          for (int j = 0; j < ((k == 0) ? c_B / 2 : c_B); j++) begin
            @(negedge CLOCK1);
            if (mon_abort) abandon = 1'b1;
          end
          bits[k] = TXD;
        end
        if (!abandon) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_frame: unexpected frame %0h, expected none", bits);
          end else begin
            e = sb.pop_front();
            check($sformatf("mon_frame_%02h", e.data), bits, {2'b11, e.data, 1'b0});
            if (e.gap != 0) check($sformatf("mon_gap_%02h", e.data), st - prev_start, e.gap);
          end
          prev_start = st;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, expected earlier finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          n_low;
    int          n_busy;
    logic [21:0] t1_exp;
    logic [3:0]  t3_exp;

    RESET = 1'b0;
    iCall = 1'b0;
    iData = 16'h0000;
    repeat (3) @(posedge CLOCK1);
    #1;
    check("rst_txd", TXD, 1);
    check("rst_done", oDone, 0);
    check("rst_level", oLevel, 0);
    check("rst_busy", oBusy, 0);
    @(posedge CLOCK1); #2;
    RESET = 1'b1;
    @(posedge CLOCK1); #1;

    // Single word 0xA000: exact bit values and widths
    t1_exp = {2'b11, 8'h00, 1'b0, 2'b11, 8'hA0, 1'b0};
    push(16'hA000, 10, w);
    sb_push_word(16'hA000, 0);
    check("t1_accept_wait", w, 1);
    check("t1_level", oLevel, 1);
    @(posedge CLOCK1); #1;
    check("t1_txd_fall", TXD, 0);
    check("t1_level_pop", oLevel, 0);
    check("t1_done_pulse", oDone, 0);
    for (int k = 0; k < 22; k++) begin
      check($sformatf("t1_bit%0d_first", k), TXD, t1_exp[k]);
      repeat (c_B - 1) @(posedge CLOCK1);
      #1;
      check($sformatf("t1_bit%0d_last", k), TXD, t1_exp[k]);
      @(posedge CLOCK1); #1;
    end
    check("t1_idle_txd", TXD, 1);
    check("t1_idle_busy", oBusy, 0);
    drain(200);

    // Fill FIFO: five accepted quickly, sixth waits for the second pop
    t2_w = '{16'hC001, 16'h5AA5, 16'h8001, 16'h00FF, 16'h7E81, 16'h3C3C};
    for (int i = 0; i < 5; i++) begin
      push(t2_w[i], 10, w);
      sb_push_word(t2_w[i], (i == 0) ? 0 : c_WGAP);
      check($sformatf("t2_wait%0d", i), w, (i == 0) ? 1 : 2);
    end
    check("t2_level_full", oLevel, 4);
    push(t2_w[5], 400, w);
    sb_push_word(t2_w[5], c_WGAP);
    check("t2_full_wait", w, 22 * c_B - 5);
    check("t2_level_after", oLevel, 4);
    drain(4000);
    check("t2_max_level", max_level, 4);

    // Handshake: iCall held three cycles past the oDone pulse
    t3_exp = 4'b0010;
    iData = 16'h5A3C;
    iCall = 1'b1;
    wait_done(10, w);
    sb_push_word(16'h5A3C, 0);
    check("t3_accept_wait", w, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLOCK1); #1;
      check($sformatf("t3_done_%0d", i), oDone, t3_exp[i]);
      if (i == 2) iCall = 1'b0;
    end
    sb_push_word(16'h5A3C, c_WGAP);
    drain(1000);

    // Back-to-back words: byte order 12,34,AB,CD
    push(16'h1234, 10, w);
    sb_push_word(16'h1234, 0);
    push(16'hABCD, 10, w);
    sb_push_word(16'hABCD, c_WGAP);
    check("t4_wait", w, 2);
    drain(1000);

    // Push landing on the IDLE pop edge with one word queued
    push(16'h0F0F, 10, w);
    sb_push_word(16'h0F0F, 0);
    push(16'hF00F, 10, w);
    sb_push_word(16'hF00F, c_WGAP);
    repeat (22 * c_B - 1) @(posedge CLOCK1);
    #1;
    check("t5_pre_level", oLevel, 1);
    check("t5_pre_txd", TXD, 1);
    iData = 16'h6699;
    iCall = 1'b1;
    @(posedge CLOCK1); #1;
    iCall = 1'b0;
    sb_push_word(16'h6699, c_WGAP);
    check("t5_done", oDone, 1);
    check("t5_level", oLevel, 1);
    check("t5_txd_start", TXD, 0);
    drain(1500);

    // Reset during data bit 4 of the second word, two words still queued
    push(16'h2468, 10, w);
    sb_push_word(16'h2468, 0);
    push(16'h2C57, 10, w);
    push(16'hFACE, 10, w);
    push(16'hBEEF, 10, w);
    repeat (27 * c_B + 2) @(posedge CLOCK1);
    #1;
    check("t6_pre_level", oLevel, 2);
    check("t6_pre_txd", TXD, 0);
    mon_abort = 1'b1;
    #3;
    RESET = 1'b0;
    #1;
    check("t6_rst_txd", TXD, 1);
    check("t6_rst_level", oLevel, 0);
    check("t6_rst_busy", oBusy, 0);
    check("t6_rst_done", oDone, 0);
    repeat (3) @(posedge CLOCK1);
    #2;
    RESET = 1'b1;
    n_low = 0;
    n_busy = 0;
    for (int i = 0; i < 2 * (22 * c_B + 1) + 10; i++) begin
      @(negedge CLOCK1);
      if (TXD !== 1'b1) n_low++;
      if (oBusy !== 1'b0) n_busy++;
    end
    check("t6_post_txd_low_cycles", n_low, 0);
    check("t6_post_busy_cycles", n_busy, 0);
    check("t6_post_level", oLevel, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
